// File: rtl/dvi_palette_lookup.sv
// dvi_palette_lookup: unpacks packed index words, reads the palette RAM and emits RGB pixels with backpressure.
module dvi_palette_lookup #(
  parameter int W_IDX = 8,
  parameter int W_RGB = 24,
  parameter int W_IN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             double_x,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  output logic             pal_ren,
  output logic [W_IDX-1:0] pal_raddr,
  input  logic [W_RGB-1:0] pal_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_RGB-1:0] out_rgb
);
  localparam int PPW = W_IN / W_IDX;
  localparam int CW  = PPW > 1 ? $clog2(PPW) : 1;

  logic [W_IN-1:0]  word_q, word_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rep_q, rep_d, full_q, full_d, infl_q;
  logic [W_RGB-1:0] mem_q [2];
  logic             rp_q, wp_q;
  logic [1:0]       lvl_q;
  logic [W_IDX-1:0] raddr_q;
  logic [2:0]       credit;
  logic             pop, push, iss, adv, fin, acc;

  assign shifted   = word_q >> (32'(cnt_q) * W_IDX);
  assign pop       = out_valid && out_ready;
  assign push      = infl_q && !flush;
  // Slots committed after this cycle: FIFO entries plus the read in flight, minus the one leaving.
  assign credit    = {1'b0, lvl_q} + {2'b0, infl_q} - {2'b0, pop};
  assign iss       = full_q && !flush && credit < 3'd2;
  assign adv       = iss && (rep_q || !double_x);
  assign fin       = adv && cnt_q == CW'(PPW - 1);
  assign in_ready  = !rst && !flush && (!full_q || fin);
  assign acc       = in_valid && in_ready;
  assign pal_ren   = iss;
  assign pal_raddr = iss ? shifted[W_IDX-1:0] : raddr_q;
  assign out_valid = lvl_q != 2'd0;
  assign out_rgb   = mem_q[rp_q];

  always_comb begin
    word_d = acc ? in_data : word_q;
    full_d = acc || (full_q && !fin);
    cnt_d  = (acc || fin) ? '0 : adv ? cnt_q + CW'(1) : cnt_q;
    rep_d  = acc ? 1'b0 : iss ? (double_x && !rep_q) : rep_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      cnt_q    <= '0;
      rep_q    <= 1'b0;
      full_q   <= 1'b0;
      infl_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      lvl_q    <= 2'd0;
      raddr_q  <= '0;
    end else begin
      raddr_q <= pal_raddr;
      word_q  <= word_d;
      if (flush) begin
        cnt_q  <= '0;
        rep_q  <= 1'b0;
        full_q <= 1'b0;
        infl_q <= 1'b0;
        rp_q   <= 1'b0;
        wp_q   <= 1'b0;
        lvl_q  <= 2'd0;
      end else begin
        cnt_q  <= cnt_d;
        rep_q  <= rep_d;
        full_q <= full_d;
        infl_q <= iss;
        if (push) mem_q[wp_q] <= pal_rdata;
        wp_q   <= wp_q ^ push;
        rp_q   <= rp_q ^ pop;
        lvl_q  <= lvl_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end
endmodule

// File: tb/tb_dvi_palette_lookup.sv
// tb_dvi_palette_lookup: scoreboard bench with a behavioural palette RAM and stall/latency checks.
module tb_dvi_palette_lookup;
  logic        clk = 0, rst = 1, flush = 0, double_x = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, pal_ren, out_valid;
  logic [7:0]  pal_raddr;
  logic [23:0] pal_rdata = 0, out_rgb;
  logic [23:0] pal [256];
  logic [23:0] exq [$];
  int          checks = 0, failures = 0;
  int          ncyc = 0, t_acc = 0, t_first = -1, t_a = 0, low = 0, seen = 0;
  int          ren_run = 0, ren_max = 0, ov_run = 0, ov_max = 0;
  logic        stall_q = 0, rnd_en = 0;
  logic [23:0] rgb_q = 0;

  always #5 clk = ~clk;

  dvi_palette_lookup dut (
    .clk(clk), .rst(rst), .flush(flush), .double_x(double_x),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pal_ren(pal_ren), .pal_raddr(pal_raddr), .pal_rdata(pal_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb)
  );

  always @(posedge clk) if (pal_ren) pal_rdata <= pal[pal_raddr];
  always @(posedge clk) ncyc++;
  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_rgb", 32'(out_rgb), 32'(rgb_q));
      end
      check("fifo_level", 32'(dut.lvl_q <= 2'd2), 1);
      if (out_valid && t_first < 0) t_first = ncyc;
      if (out_valid && out_ready) begin
        if (exq.size() == 0) check("spurious_out", 32'(out_rgb), 32'hDEAD);
        else check("rgb", 32'(out_rgb), 32'(exq.pop_front()));
      end
      ren_run = pal_ren ? ren_run + 1 : 0;
      ov_run  = (out_valid && out_ready) ? ov_run + 1 : 0;
      if (ren_run > ren_max) ren_max = ren_run;
      if (ov_run > ov_max) ov_max = ov_run;
    end
    stall_q = !rst && out_valid && !out_ready && !flush;
    rgb_q   = out_rgb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit expect_out);
    int n = 0;
    in_valid = 1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("accept_timeout", 32'(n < 200), 1);
    t_acc = ncyc;
    if (expect_out)
      for (int k = 0; k < 4; k++)
        repeat (double_x ? 2 : 1) exq.push_back(pal[w[8*k +: 8]]);
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exq.size() != 0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("drain", exq.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pal[i] = 24'(i * 32'h010101);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ren", 32'(pal_ren), 0);
    check("rst_raddr", 32'(pal_raddr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_rgb", 32'(out_rgb), 0);
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);
    tick();

    out_ready = 1;
    t_first = -1;
    send(32'h03020100, 1);
    drain();
    check("latency", t_first - t_acc, 3);

    ren_max = 0;
    ov_max = 0;
    send(32'h87654321, 1);
    t_a = t_acc;
    send(32'hF0E1D2C3, 1);
    check("b2b_accept_gap", t_acc - t_a, 4);
    drain();
    check("ren_run", ren_max, 8);
    check("out_run", ov_max, 8);

    rnd_en = 1;
    for (int i = 0; i < 8; i++) send($urandom, 1);
    drain();
    rnd_en = 0;
    tick();
    out_ready = 1;

    double_x = 1;
    tick();
    send(32'h0A0B0C0D, 1);
    low = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!in_ready) low++;
    end
    check("dbl_in_ready_low", low, 7);
    drain();
    double_x = 0;
    tick();

    out_ready = 0;
    send(32'h11223344, 0);
    @(negedge clk);
    check("pre_flush_ren", 32'(pal_ren), 1);
    tick();
    flush = 1;
    tick();
    flush = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_flush_valid", seen, 0);
    tick();
    out_ready = 1;
    send(32'h04050607, 1);
    drain();

    out_ready = 0;
    send(32'h00000009, 0);
    seen = 0;
    @(negedge clk);
    while (!out_valid && seen < 50) begin
      seen++;
      @(negedge clk);
    end
    check("stall_valid", 32'(out_valid), 1);
    #2;
    rst = 1;
    #1;
    check("async_out_valid", 32'(out_valid), 0);
    check("async_out_rgb", 32'(out_rgb), 0);
    check("async_ren", 32'(pal_ren), 0);
    check("async_in_ready", 32'(in_ready), 0);
    check("async_full", 32'(dut.full_q), 0);
    exq.delete();
    tick();
    tick();
    rst = 0;
    out_ready = 1;
    tick();
    send(32'hFFEE8001, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
